// File: rtl/pt_cache_multi_if.sv
// Command/stream bundle between process-control front end and page-table cache.
// master: cmd, PID, datain, datavalid, inv out; slave: pagefault, dataout, outvalid, wd, busy out.
interface pt_cache_multi_if #(
    parameter int PIDW = 4,
    parameter int DW   = 8
);
    logic [1:0]      cmd;
    logic [PIDW-1:0] PID;
    logic [DW-1:0]   datain;
    logic            datavalid;
    logic            inv;
    logic            pagefault;
    logic [DW-1:0]   dataout;
    logic            outvalid;
    logic            wd;
    logic            busy;

    modport master (
        output cmd, PID, datain, datavalid, inv,
        input  pagefault, dataout, outvalid, wd, busy
    );

    modport slave (
        input  cmd, PID, datain, datavalid, inv,
        output pagefault, dataout, outvalid, wd, busy
    );
endinterface

// File: rtl/pt_cache_multi.sv
// Multi-process page-table cache: PID-tagged slots, round-robin replacement.
// Ports: clk, rst (sync, active-high), bus (pt_cache_multi_if.slave).
module pt_cache_multi #(
    parameter int NSLOT = 4,
    parameter int PIDW  = 4,
    parameter int DIRW  = 2,
    parameter int PGW   = 2,
    parameter int DW    = 8
) (
    input  logic               clk,
    input  logic               rst,
    pt_cache_multi_if.slave    bus
);
    localparam int AW   = DIRW + PGW;
    localparam int PTD  = 1 << AW;
    localparam int NDIR = 1 << DIRW;
    localparam int NOUT = PTD + NDIR + 1;
    localparam int SW   = $clog2(NSLOT);
    localparam int CW   = $clog2(NOUT);

    localparam logic [1:0] C_NOP = 2'b00;
    localparam logic [1:0] C_RD  = 2'b01;
    localparam logic [1:0] C_WR  = 2'b10;
    localparam logic [1:0] C_LD  = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_WPT, S_WDIR, S_WDONE,
        S_RLOOK, S_RDIR, S_RPT, S_RDONE,
        S_LLOOK, S_LOUT
    } state_t;

    state_t            r_state, w_next;
    logic [DW-1:0]     r_tab [NSLOT][PTD];
    logic [DW-1:0]     r_dir [NSLOT][NDIR];
    logic [PIDW-1:0]   r_tag [NSLOT];
    logic [NSLOT-1:0]  r_valid;
    logic [SW-1:0]     r_victim;
    logic [SW-1:0]     r_slot;
    logic [PIDW-1:0]   r_pid;
    logic [AW-1:0]     r_addr;
    logic [AW-1:0]     r_base;
    logic [DW-1:0]     r_byte;
    logic [CW-1:0]     r_idx;
    logic              r_fault;

    logic [PIDW-1:0]   w_lpid;
    logic              w_hit;
    logic [SW-1:0]     w_hslot;
    logic              w_free;
    logic [SW-1:0]     w_fslot;
    logic [SW-1:0]     w_wslot;
    logic [AW-1:0]     w_ridx;
    logic [CW-1:0]     w_doff;
    logic              w_last_pt;
    logic              w_last_dir;

    // In IDLE the lookup uses the live PID (WR slot choice at accept);
    // in the LOOK states it uses the PID latched at accept.
    always_comb begin
        w_lpid  = (r_state == S_IDLE) ? bus.PID : r_pid;
        w_hit   = 1'b0;
        w_hslot = '0;
        for (int s = 0; s < NSLOT; s++) begin
            if (r_valid[s] && r_tag[s] == w_lpid) begin
                w_hit   = 1'b1;
                w_hslot = SW'(s);
            end
        end
        w_free  = 1'b0;
        w_fslot = '0;
        for (int s = NSLOT - 1; s >= 0; s--) begin
            if (!r_valid[s]) begin
                w_free  = 1'b1;
                w_fslot = SW'(s);
            end
        end
        if (w_hit)       w_wslot = w_hslot;
        else if (w_free) w_wslot = w_fslot;
        else             w_wslot = r_victim;
    end

    assign w_ridx     = r_base + AW'(r_addr[PGW-1:0]);
    assign w_doff     = r_idx - CW'(PTD);
    assign w_last_pt  = (r_idx == CW'(PTD - 1));
    assign w_last_dir = (r_idx == CW'(NDIR - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                case (bus.cmd)
                    C_RD:    w_next = S_RLOOK;
                    C_WR:    w_next = S_WPT;
                    C_LD:    w_next = S_LLOOK;
                    default: w_next = S_IDLE;
                endcase
            end
            S_WPT:   if (bus.datavalid && w_last_pt) w_next = S_WDIR;
            S_WDIR:  if (w_last_dir) w_next = S_WDONE;
            S_WDONE: w_next = S_IDLE;
            S_RLOOK: w_next = w_hit ? S_RDIR : S_RDONE;
            S_RDIR:  w_next = S_RPT;
            S_RPT:   w_next = S_RDONE;
            S_RDONE: w_next = S_IDLE;
            S_LLOOK: w_next = w_hit ? S_LOUT : S_RDONE;
            S_LOUT:  if (r_idx == CW'(NOUT - 1)) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= '0;
            r_victim <= '0;
            r_slot   <= '0;
            r_pid    <= '0;
            r_addr   <= '0;
            r_base   <= '0;
            r_byte   <= '0;
            r_idx    <= '0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_idx   <= '0;
                    r_fault <= 1'b0;
                    if (bus.cmd != C_NOP) begin
                        r_pid  <= bus.PID;
                        r_addr <= bus.datain[DW-1 -: AW];
                        if (bus.cmd == C_WR) begin
                            // Invalidate now so a half-written slot never hits.
                            r_slot           <= w_wslot;
                            r_valid[w_wslot] <= 1'b0;
                            if (!w_hit && !w_free)
                                r_victim <= r_victim + 1'b1;
                        end
                    end else if (bus.inv) begin
                        r_valid  <= '0;
                        r_victim <= '0;
                    end
                end
                S_WPT: begin
                    if (bus.datavalid)
                        r_idx <= w_last_pt ? '0 : r_idx + 1'b1;
                end
                S_WDIR: r_idx <= w_last_dir ? '0 : r_idx + 1'b1;
                S_WDONE: r_valid[r_slot] <= 1'b1;
                S_RLOOK, S_LLOOK: begin
                    r_idx <= '0;
                    if (w_hit) r_slot  <= w_hslot;
                    else       r_fault <= 1'b1;
                end
                S_RDIR: r_base <= r_dir[r_slot][r_addr[AW-1 -: DIRW]][AW-1:0];
                S_RPT:  r_byte <= r_tab[r_slot][w_ridx];
                S_LOUT: r_idx  <= r_idx + 1'b1;
                default: ;
            endcase
        end
    end

    // Table storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (r_state == S_WPT && bus.datavalid)
            r_tab[r_slot][r_idx[AW-1:0]] <= bus.datain;
        if (r_state == S_WDIR)
            r_dir[r_slot][r_idx[DIRW-1:0]] <= DW'(r_idx[DIRW-1:0]) << PGW;
        if (r_state == S_WDONE)
            r_tag[r_slot] <= r_pid;
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.wd        = (r_state == S_WDONE);
    assign bus.pagefault = (r_state == S_RDONE) && r_fault;
    assign bus.outvalid  = ((r_state == S_RDONE) && !r_fault)
                         || (r_state == S_LOUT);

    always_comb begin
        bus.dataout = '0;
        if (r_state == S_RDONE && !r_fault) begin
            bus.dataout = r_byte;
        end else if (r_state == S_LOUT) begin
            if (r_idx < CW'(PTD))
                bus.dataout = r_tab[r_slot][r_idx[AW-1:0]];
            else if (r_idx < CW'(PTD + NDIR))
                bus.dataout = r_dir[r_slot][w_doff[DIRW-1:0]];
            else
                bus.dataout = DW'(r_tag[r_slot]);
        end
    end
endmodule

// File: tb/tb_pt_cache_multi.sv
// Directed self-checking bench for pt_cache_multi.
// Drives the master side of pt_cache_multi_if; samples on the falling edge.
module tb_pt_cache_multi;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pt_cache_multi_if #(.PIDW(4), .DW(8)) bus ();

    pt_cache_multi #(
        .NSLOT(4), .PIDW(4), .DIRW(2), .PGW(2), .DW(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [3:0] pid, input logic [7:0] a,
                      input bit hit, input logic [7:0] exp,
                      input string tg, input bit inv_a = 1'b0);
        int ov_at = -1, pf_at = -1, ov_n = 0, pf_n = 0, bad0 = 0;
        logic [7:0] got = '0;
        logic b5 = 1'b0;
        @(negedge clk);
        bus.cmd = 2'b01; bus.PID = pid; bus.datain = a; bus.inv = inv_a;
        @(negedge clk);
        bus.cmd = 2'b00; bus.PID = '0; bus.datain = 8'hFF; bus.inv = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 1) check({tg, "_busy1"}, bus.busy, 1);
            if (bus.outvalid) begin
                ov_n++; ov_at = c; got = bus.dataout;
            end else if (bus.dataout != 0) begin
                bad0++;
            end
            if (bus.pagefault) begin
                pf_n++; pf_at = c;
            end
            if (c == 5) b5 = bus.busy;
            @(negedge clk);
        end
        if (hit) begin
            check({tg, "_ov_cyc"}, ov_at, 4);
            check({tg, "_ov_n"}, ov_n, 1);
            check({tg, "_data"}, got, exp);
            check({tg, "_pf_n"}, pf_n, 0);
            check({tg, "_busy5"}, b5, 0);
        end else begin
            check({tg, "_pf_cyc"}, pf_at, 2);
            check({tg, "_pf_n"}, pf_n, 1);
            check({tg, "_ov_n"}, ov_n, 0);
        end
        check({tg, "_dout0"}, bad0, 0);
    endtask

    task automatic wr(input logic [3:0] pid, input logic [7:0] base,
                      input string tg);
        int wd_n = 0, wd_at = -1;
        @(negedge clk);
        bus.cmd = 2'b10; bus.PID = pid;
        @(negedge clk);
        bus.cmd = 2'b00; bus.PID = '0;
        check({tg, "_busy"}, bus.busy, 1);
        for (int i = 0; i < 16; i++) begin
            wd_n += int'(bus.wd);
            if (i == 5) begin
                bus.datavalid = 1'b0;
                @(negedge clk);
                wd_n += int'(bus.wd);
            end
            bus.datavalid = 1'b1;
            bus.datain = base + 8'(i);
            @(negedge clk);
        end
        bus.datavalid = 1'b0;
        bus.datain = '0;
        for (int k = 1; k <= 8; k++) begin
            if (bus.wd) begin
                wd_n++; wd_at = k;
            end
            @(negedge clk);
        end
        check({tg, "_wd_cyc"}, wd_at, 5);
        check({tg, "_wd_n"}, wd_n, 1);
        check({tg, "_idle"}, bus.busy, 0);
    endtask

    task automatic ld(input logic [3:0] pid, input logic [7:0] base,
                      input bit hit, input string tg);
        int first = -1, n = 0, pf_at = -1, pf_n = 0, bad0 = 0;
        logic [7:0] e;
        @(negedge clk);
        bus.cmd = 2'b11; bus.PID = pid;
        @(negedge clk);
        bus.cmd = 2'b00; bus.PID = '0;
        for (int c = 1; c <= 25; c++) begin
            if (bus.outvalid) begin
                if (first < 0) first = c;
                if (n < 16)      e = base + 8'(n);
                else if (n < 20) e = 8'((n - 16) << 2);
                else             e = 8'(pid);
                if (n < 21) check($sformatf("%s_b%0d", tg, n), bus.dataout, e);
                n++;
            end else if (bus.dataout != 0) begin
                bad0++;
            end
            if (bus.pagefault) begin
                pf_n++; pf_at = c;
            end
            @(negedge clk);
        end
        if (hit) begin
            check({tg, "_first"}, first, 2);
            check({tg, "_count"}, n, 21);
            check({tg, "_pf_n"}, pf_n, 0);
        end else begin
            check({tg, "_pf_cyc"}, pf_at, 2);
            check({tg, "_pf_n"}, pf_n, 1);
            check({tg, "_count"}, n, 0);
        end
        check({tg, "_dout0"}, bad0, 0);
    endtask

    task automatic wr_reset(input logic [3:0] pid, input string tg);
        @(negedge clk);
        bus.cmd = 2'b10; bus.PID = pid;
        @(negedge clk);
        bus.cmd = 2'b00; bus.PID = '0;
        for (int i = 0; i < 7; i++) begin
            bus.datavalid = 1'b1;
            bus.datain = 8'h60 + 8'(i);
            @(negedge clk);
        end
        bus.datavalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check({tg, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        bus.cmd = 2'b00; bus.PID = '0; bus.datain = '0;
        bus.datavalid = 1'b0; bus.inv = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_pf", bus.pagefault, 0);
        check("rst_ov", bus.outvalid, 0);
        check("rst_wd", bus.wd, 0);
        check("rst_dout", bus.dataout, 0);
        rst = 1'b0;

        rd(4'd5, 8'h90, 0, 8'h00, "rd_empty");
        wr(4'd3, 8'h10, "wr3");
        rd(4'd3, 8'h90, 1, 8'h19, "rd3_90");
        rd(4'd3, 8'h00, 1, 8'h10, "rd3_00");
        rd(4'd3, 8'h7C, 1, 8'h17, "rd3_7c");
        ld(4'd3, 8'h10, 1, "ld3");
        ld(4'd5, 8'h00, 0, "ld_miss");

        rd(4'd3, 8'h90, 1, 8'h19, "rd_inv_cmd", 1'b1);
        @(negedge clk); bus.inv = 1'b1;
        @(negedge clk); bus.inv = 1'b0;
        rd(4'd3, 8'h90, 0, 8'h00, "rd_after_inv");

        wr(4'd1, 8'hA0, "wr1");
        wr(4'd2, 8'hB0, "wr2");
        wr(4'd3, 8'hC0, "wr3b");
        wr(4'd4, 8'hD0, "wr4");
        wr(4'd6, 8'hE0, "wr6");
        rd(4'd1, 8'h90, 0, 8'h00, "rd1_evict");
        rd(4'd2, 8'h90, 1, 8'hB9, "rd2");
        rd(4'd6, 8'h90, 1, 8'hE9, "rd6");
        wr(4'd7, 8'hF0, "wr7");
        rd(4'd2, 8'h90, 0, 8'h00, "rd2_evict");
        rd(4'd7, 8'h90, 1, 8'hF9, "rd7");
        wr(4'd3, 8'h20, "wr3_re");
        rd(4'd3, 8'h90, 1, 8'h29, "rd3_re");
        wr(4'd8, 8'h50, "wr8");
        rd(4'd3, 8'h90, 0, 8'h00, "rd3_evict");
        rd(4'd4, 8'h90, 1, 8'hD9, "rd4_kept");
        rd(4'd8, 8'h90, 1, 8'h59, "rd8");

        wr_reset(4'd9, "wr9_rst");
        rd(4'd9, 8'h90, 0, 8'h00, "rd9_rst");
        rd(4'd4, 8'h90, 0, 8'h00, "rd4_rst");

        $display("%0d/%0d checks passed", n_chk - n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/pt_cache_multi.md
# pt_cache_multi

Parametrised successor to the two-process page-table cache. It holds translation tables for NSLOT processes, tagged by PID, with per-slot valid bits and round-robin replacement. It supports table write, two-level translate-read and slot dump. It sits between the process-control front end, which issues commands and streams table bytes, and the memory-access path, which consumes translated bytes or page faults.

## Interface
- NSLOT, 4: number of process slots, power of 2, ≥2.
- PIDW, 4: PID width.
- DIRW, 2: directory index bits; 2^DIRW directory entries per slot.
- PGW, 2: page index bits; table depth PTD = 2^(DIRW+PGW) = 16.
- DW, 8: data width. Requires DIRW+PGW ≤ DW and PIDW ≤ DW.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd  in  2  NOP=00, RD=01, WR=10, LD=11; sampled only in IDLE.
- PID  in  PIDW  process ID; sampled when a cmd is accepted.
- datain  in  DW  WR: table byte. RD: virtual address, sampled at accept.
- datavalid  in  1  one-cycle strobe per WR byte; level-sampled, not edge-triggered.
- inv  in  1  in IDLE with cmd=NOP: clear all valid bits and the victim pointer.
- pagefault  out  1  one-cycle pulse: RD or LD found no valid slot with a matching PID.
- dataout  out  DW  valid only with outvalid; 0 otherwise.
- outvalid  out  1  RD result or LD stream byte.
- wd  out  1  one-cycle pulse: WR sequence complete and slot valid.
- busy  out  1  high in every state except IDLE.

## Operation
- Per-slot storage: table[PTD]×DW, dir[2^DIRW]×DW, tag PIDW, valid bit. Victim pointer is log2(NSLOT) bits.
- Slot hit means valid and tag==PID. At most one slot can hit; WR guarantees uniqueness.
- States and transitions:
  - IDLE: RD→RLOOK, WR→WPT, LD→LLOOK. NOP stays in IDLE.
  - WPT: stores each datavalid byte at table[idx] and increments idx. Moves to WDIR when idx reaches PTD-1 and that byte is stored. datavalid outside WPT is ignored.
  - WDIR: writes dir[d] = d<<PGW, one entry per cycle, then moves to WDONE.
  - WDONE: sets tag=PID and valid=1, pulses wd, then goes to IDLE.
  - RLOOK: on hit → RDIR. On miss → RDONE with fault flag set.
  - RDIR: base = dir[datain_s[DW-1 -: DIRW]], then RPT.
  - RPT: byte = table[base + datain_s[DW-1-DIRW -: PGW]], where the index is truncated to DIRW+PGW bits. Then RDONE.
  - RDONE: drives outvalid=1 with byte, or pagefault=1. Then IDLE.
  - LLOOK: on hit → LOUT. On miss → pagefault pulse, then IDLE.
  - LOUT: emits one byte per cycle with outvalid=1, in order table[0..PTD-1], dir[0..2^DIRW-1], tag zero-extended. That is PTD+2^DIRW+1 bytes, 21 at defaults. Then IDLE.
- WR slot choice, fixed at accept:
  - If the PID hits, reuse that slot.
  - Otherwise use the lowest-index invalid slot.
  - Otherwise use the victim-pointer slot, and increment the pointer modulo NSLOT.
  - The chosen slot's valid bit is cleared at accept, so a partial write never hits.
- cmd, PID and datain (RD) are latched at accept. They need not be held afterwards.

## Timing
- Reset (any state): state=IDLE, all valid=0, victim=0, idx=0. pagefault, outvalid, wd and busy are 0; dataout=0. Table contents are not cleared.
- Accept edge is cycle 0. busy rises in cycle 1.
- RD hit: outvalid high in cycle 4 for exactly 1 cycle. busy drops in cycle 5.
- RD miss: pagefault high in cycle 2 for exactly 1 cycle.
- LD hit: bytes on cycles 2 .. 2+PTD+2^DIRW. LD miss: pagefault in cycle 2.
- WR: wd pulses 2^DIRW+1 cycles after the edge that stores the last table byte.
- inv with cmd≠NOP in IDLE: the cmd wins and inv is ignored.
- Reset mid-WR: the slot being written stays invalid, because all valids are cleared.

## Test plan
- WR PID=3 with bytes 0x10..0x1F, then RD PID=3 with datain=0x90 (dir 2→base 8, page 1) → dataout=0x19 and outvalid in cycle 4; wd seen once after the WR.
- RD PID=5 on an empty cache → pagefault for 1 cycle in cycle 2, outvalid=0, dataout=0.
- WR PIDs 1,2,3,4, then WR PID 6 → slot 0 replaced. RD PID 1 faults; RD PID 2 hits. A following WR PID 7 replaces slot 1.
- Rewrite PID 3 with bytes 0x20..0x2F → same slot reused and victim pointer unchanged. RD datain=0x90 → 0x29.
- LD PID=3 after the first scenario → 21 consecutive outvalid bytes: 0x10..0x1F, 0x00, 0x04, 0x08, 0x0C, 0x03.
- Assert rst after 7 WR bytes, then RD PID=3 → pagefault. Separately, inv in IDLE → every PID faults.
